// File: rtl/decode_sequencer.sv
// decode_sequencer: splits fetch beats into PC-tagged instructions for
// the decoder, lower half first; halts on the first all-zero word.
module decode_sequencer #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int ADDR_WIDTH     = 64,
  parameter int COUNT_WIDTH    = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [ADDR_WIDTH-1:0]       entry_pc,
  input  logic                        fetch_valid,
  input  logic [BUS_DATA_WIDTH-1:0]   fetch_data,
  output logic                        fetch_ready,
  output logic                        dec_valid,
  input  logic                        dec_ready,
  output logic [BUS_DATA_WIDTH/2-1:0] dec_instruction,
  output logic [ADDR_WIDTH-1:0]       dec_pc,
  output logic                        halted,
  output logic [ADDR_WIDTH-1:0]       halt_pc,
  output logic [COUNT_WIDTH-1:0]      inst_count
);

  localparam int IW = BUS_DATA_WIDTH / 2;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_BEAT,
    ISSUE_LO,
    ISSUE_HI,
    HALT
  } state_t;

  state_t                    state_q, state_d;
  logic [BUS_DATA_WIDTH-1:0] beat_q, beat_d;
  logic [ADDR_WIDTH-1:0]     pc_q, pc_d;
  logic [ADDR_WIDTH-1:0]     halt_pc_q, halt_pc_d;
  logic [COUNT_WIDTH-1:0]    count_q, count_d;
  logic [IW-1:0]             half;
  logic                      issuing;
  logic                      zero_word;
  logic                      xfer;
  logic                      unused_pc_lsbs;

  assign unused_pc_lsbs = ^entry_pc[1:0];

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    pc_d        = pc_q;
    halt_pc_d   = halt_pc_q;
    count_d     = count_q;
    fetch_ready = 1'b0;
    issuing     = 1'b0;
    half        = '0;

    unique case (state_q)
      IDLE, HALT: begin
        if (start) begin
          pc_d    = {entry_pc[ADDR_WIDTH-1:2], 2'b00};
          count_d = '0;
          state_d = WAIT_BEAT;
        end
      end
      WAIT_BEAT: begin
        fetch_ready = 1'b1;
        if (fetch_valid) begin
          beat_d  = fetch_data;
          state_d = pc_q[2] ? ISSUE_HI : ISSUE_LO;
        end
      end
      ISSUE_LO: begin
        issuing = 1'b1;
        half    = beat_q[IW-1:0];
      end
      ISSUE_HI: begin
        issuing = 1'b1;
        half    = beat_q[BUS_DATA_WIDTH-1:IW];
      end
      default: state_d = IDLE;
    endcase

    zero_word       = issuing && (half == '0);
    dec_valid       = issuing && !zero_word;
    xfer            = dec_valid && dec_ready;
    dec_instruction = issuing ? half : '0;
    dec_pc          = issuing ? pc_q : '0;

    // The terminating zero word is reported, never presented or counted.
    if (zero_word) begin
      state_d   = HALT;
      halt_pc_d = pc_q;
    end else if (xfer) begin
      pc_d    = pc_q + ADDR_WIDTH'(4);
      count_d = count_q + COUNT_WIDTH'(1);
      state_d = (state_q == ISSUE_LO) ? ISSUE_HI : WAIT_BEAT;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      beat_q    <= '0;
      pc_q      <= '0;
      halt_pc_q <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      pc_q      <= pc_d;
      halt_pc_q <= halt_pc_d;
      count_q   <= count_d;
    end
  end

  assign halted     = (state_q == HALT);
  assign halt_pc    = halt_pc_q;
  assign inst_count = count_q;

endmodule

// File: tb/tb_decode_sequencer.sv
// tb_decode_sequencer: randomized stream checks against a PC-level
// model of which words the decoder must see and where the halt lands.
module tb_decode_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [63:0] entry_pc = '0;
  logic        fetch_valid = 1'b0;
  logic [63:0] fetch_data = '0;
  logic        fetch_ready;
  logic        dec_valid;
  logic        dec_ready = 1'b0;
  logic [31:0] dec_instruction;
  logic [63:0] dec_pc;
  logic        halted;
  logic [63:0] halt_pc;
  logic [31:0] inst_count;

  logic        unused_fr4, unused_dv4, unused_h4;
  logic [31:0] unused_di4;
  logic [63:0] unused_dp4, unused_hp4;
  logic [3:0]  count4;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [31:0] instr;
    logic [63:0] pc;
    int          beat;
  } xfer_t;

  xfer_t       q[$];
  logic [63:0] prog[16];

  always #5 clk = ~clk;

  decode_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .entry_pc(entry_pc),
    .fetch_valid(fetch_valid), .fetch_data(fetch_data),
    .fetch_ready(fetch_ready), .dec_valid(dec_valid),
    .dec_ready(dec_ready), .dec_instruction(dec_instruction),
    .dec_pc(dec_pc), .halted(halted), .halt_pc(halt_pc),
    .inst_count(inst_count)
  );

  decode_sequencer #(.COUNT_WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .start(start), .entry_pc(entry_pc),
    .fetch_valid(fetch_valid), .fetch_data(fetch_data),
    .fetch_ready(unused_fr4), .dec_valid(unused_dv4),
    .dec_ready(dec_ready), .dec_instruction(unused_di4),
    .dec_pc(unused_dp4), .halted(unused_h4), .halt_pc(unused_hp4),
    .inst_count(count4)
  );

  task automatic clear_prog();
    for (int i = 0; i < 16; i++) prog[i] = '0;
  endtask

  // Drives one start-to-halt run; every observed cycle is checked.
  task automatic run_stream(input logic [63:0] entry, input int nbeats,
                            input int rdy_pct, input int fv_pct,
                            input int hold);
    xfer_t       e;
    logic [63:0] pc, exp_halt;
    logic [31:0] w;
    int          b, cnt, bi, holdleft;
    bit          done, f_acc, f_lo, f_hi, exp_dv;
    q.delete();
    pc = {entry[63:2], 2'b00};
    b  = 0;
    for (int k = 0; k < 40 && b < 16; k++) begin
      w = pc[2] ? prog[b][63:32] : prog[b][31:0];
      if (w == 0) break;
      e.instr = w; e.pc = pc; e.beat = b;
      q.push_back(e);
      pc = pc + 64'd4;
      if (!pc[2]) b++;
    end
    exp_halt = pc;
    cnt = 0; bi = 0; holdleft = hold;
    done = 0; f_acc = 0; f_lo = 0; f_hi = 0; exp_dv = 0;

    @(negedge clk);
    entry_pc = entry; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    vectors++;
    if (fetch_ready !== 1'b1 || halted !== 1'b0 || inst_count !== 0)
      begin
        miscompares++;
        $display("FAIL start_state: fr=%b halted=%b cnt=%0d, need 1 0 0",
                 fetch_ready, halted, inst_count);
      end
    for (int cyc = 0; cyc < 2000 && !done; cyc++) begin
      if (cyc != 0) @(negedge clk);
      if (f_hi) begin
        vectors++;
        if (fetch_ready !== 1'b1) begin
          miscompares++;
          $display("FAIL ready_after_hi: fr=%b need 1", fetch_ready);
        end
      end
      if (f_acc || f_lo) begin
        vectors++;
        if (dec_valid !== exp_dv || (f_acc && fetch_ready !== 1'b0)) begin
          miscompares++;
          $display("FAIL latency: dv=%b fr=%b need dv=%b fr=0",
                   dec_valid, fetch_ready, exp_dv);
        end
      end
      f_acc = 0; f_lo = 0; f_hi = 0;
      if (halted) begin
        vectors++;
        if (halt_pc !== exp_halt || inst_count !== cnt ||
            count4 !== 4'(cnt) || q.size() != 0 ||
            fetch_ready !== 1'b0 || dec_valid !== 1'b0) begin
          miscompares++;
          $display("FAIL halt: pc=%h cnt=%0d c4=%0d left=%0d, need pc=%h cnt=%0d",
                   halt_pc, inst_count, count4, q.size(), exp_halt, cnt);
        end
        done = 1;
      end else begin
        if (dec_valid) begin
          vectors++;
          if (q.size() == 0) begin
            miscompares++;
            $display("FAIL extra_issue: got %h@%h, need none",
                     dec_instruction, dec_pc);
          end else if (dec_instruction !== q[0].instr ||
                       dec_pc !== q[0].pc || inst_count !== cnt ||
                       count4 !== 4'(cnt)) begin
            miscompares++;
            $display("FAIL issue: got %h@%h cnt=%0d, need %h@%h cnt=%0d",
                     dec_instruction, dec_pc, inst_count,
                     q[0].instr, q[0].pc, cnt);
          end
        end
        if (holdleft > 0) begin
          dec_ready = 1'b0;
          if (dec_valid) holdleft--;
        end else begin
          dec_ready = ($urandom_range(99) < rdy_pct);
        end
        if (dec_valid && dec_ready && q.size() != 0) begin
          e = q.pop_front();
          cnt++;
          if (e.pc[2]) f_hi = 1;
          else begin
            f_lo   = 1;
            exp_dv = (q.size() != 0) && (q[0].beat == e.beat);
          end
        end
        fetch_valid = (bi < nbeats) && ($urandom_range(99) < fv_pct);
        fetch_data  = fetch_valid ? prog[bi] : {$urandom, $urandom};
        if (fetch_valid && fetch_ready) begin
          f_acc  = 1;
          exp_dv = (q.size() != 0) && (q[0].beat == bi);
          bi++;
        end
      end
    end
    if (!done) begin
      miscompares++;
      $display("FAIL timeout: halted=%b, need 1", halted);
    end
    fetch_valid = 1'b0;
    dec_ready   = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if (fetch_ready !== 0 || dec_valid !== 0 || dec_instruction !== 0 ||
        dec_pc !== 0 || halted !== 0 || halt_pc !== 0 ||
        inst_count !== 0 || count4 !== 0) begin
      miscompares++;
      $display("FAIL reset: fr=%b dv=%b di=%h pc=%h h=%b hp=%h c=%0d, need 0",
               fetch_ready, dec_valid, dec_instruction, dec_pc, halted,
               halt_pc, inst_count);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    clear_prog();
    prog[0] = 64'h00500093_00a00513;
    run_stream(64'h1000, 2, 100, 100, 0);
    vectors++;
    if (halt_pc !== 64'h1008 || inst_count !== 2) begin
      miscompares++;
      $display("FAIL basic: hp=%h cnt=%0d, need 1008 2", halt_pc, inst_count);
    end
  endtask

  task automatic test_backpressure();
    clear_prog();
    prog[0] = 64'h00500093_00a00513;
    run_stream(64'h1000, 2, 100, 100, 5);
  endtask

  task automatic test_misaligned();
    clear_prog();
    prog[0] = 64'h00000013_deadbeef;
    run_stream(64'h2006, 2, 100, 100, 0);
    vectors++;
    if (halt_pc !== 64'h2008 || inst_count !== 1) begin
      miscompares++;
      $display("FAIL misaligned: hp=%h cnt=%0d, need 2008 1",
               halt_pc, inst_count);
    end
  endtask

  task automatic test_upper_zero();
    clear_prog();
    prog[0] = 64'h00000000_00000013;
    run_stream(64'h1800, 1, 60, 60, 0);
    vectors++;
    if (halt_pc !== 64'h1804 || inst_count !== 1) begin
      miscompares++;
      $display("FAIL upper_zero: hp=%h cnt=%0d, need 1804 1",
               halt_pc, inst_count);
    end
  endtask

  task automatic test_restart();
    bit seen;
    @(negedge clk);
    entry_pc = 64'h3000; start = 1'b1;
    @(negedge clk);
    vectors++;
    if (halted !== 0 || inst_count !== 0 || fetch_ready !== 1) begin
      miscompares++;
      $display("FAIL restart: h=%b cnt=%0d fr=%b, need 0 0 1",
               halted, inst_count, fetch_ready);
    end
    entry_pc    = 64'h5000;
    fetch_valid = 1'b1;
    fetch_data  = 64'h00000000_00000013;
    @(negedge clk);
    start = 1'b0; fetch_valid = 1'b0; dec_ready = 1'b1;
    vectors++;
    if (dec_valid !== 1 || dec_pc !== 64'h3000 ||
        dec_instruction !== 32'h13) begin
      miscompares++;
      $display("FAIL start_ignored: dv=%b %h@%h, need 1 00000013@3000",
               dec_valid, dec_instruction, dec_pc);
    end
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = halted;
    end
    vectors++;
    if (!seen || halt_pc !== 64'h3004 || inst_count !== 1) begin
      miscompares++;
      $display("FAIL restart_halt: h=%b hp=%h cnt=%0d, need 1 3004 1",
               halted, halt_pc, inst_count);
    end
    dec_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit seen;
    @(negedge clk);
    entry_pc = 64'h1000; start = 1'b1;
    @(negedge clk);
    start = 1'b0; fetch_valid = 1'b1;
    fetch_data = 64'h00500093_00a00513;
    dec_ready = 1'b0;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      fetch_valid = 1'b0;
      seen = dec_valid;
    end
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL mid_issue: dv=%b need 1", dec_valid);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    vectors++;
    if (fetch_ready !== 0 || dec_valid !== 0 || dec_instruction !== 0 ||
        dec_pc !== 0 || halted !== 0 || halt_pc !== 0 ||
        inst_count !== 0) begin
      miscompares++;
      $display("FAIL reset_mid: fr=%b dv=%b di=%h pc=%h h=%b c=%0d, need 0",
               fetch_ready, dec_valid, dec_instruction, dec_pc, halted,
               inst_count);
    end
    fetch_valid = 1'b1;
    @(negedge clk);
    fetch_valid = 1'b0;
    vectors++;
    if (fetch_ready !== 0 || dec_valid !== 0) begin
      miscompares++;
      $display("FAIL idle_ignores_fetch: fr=%b dv=%b, need 0 0",
               fetch_ready, dec_valid);
    end
  endtask

  task automatic test_wrap();
    clear_prog();
    for (int i = 0; i < 8; i++)
      prog[i] = {32'h00100093 + 32'(i), 32'h00a00513 + 32'(i)};
    prog[8] = 64'h00000000_00000013;
    run_stream(64'h4000, 10, 80, 80, 0);
    vectors++;
    if (inst_count !== 17 || count4 !== 4'd1) begin
      miscompares++;
      $display("FAIL wrap: cnt=%0d c4=%0d, need 17 1", inst_count, count4);
    end
  endtask

  task automatic test_random();
    int n;
    for (int it = 0; it < 12; it++) begin
      clear_prog();
      n = $urandom_range(6, 1);
      for (int i = 0; i < n; i++)
        for (int h = 0; h < 2; h++)
          if ($urandom_range(99) >= 8)
            prog[i][h*32 +: 32] = $urandom | 32'h1;
      run_stream({$urandom, $urandom}, n + 1, $urandom_range(90, 30),
                 $urandom_range(90, 30), $urandom_range(3));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_misaligned();
    test_upper_zero();
    test_restart();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/decode_sequencer.md
Name: decode_sequencer

Overview:
- Sequences instruction fetch into the instruction decoder.
- Accepts 64-bit fetch beats, splits each into two 32-bit instructions, and presents them one per handshake (lower half first), each tagged with its PC.
- Stops at the first all-zero instruction word, reports the halt, and waits for a restart.
- Sits between the memory fetch path and the instruction decoder/printer.

Parameters:
- BUS_DATA_WIDTH, 64, fetch beat width; each instruction is BUS_DATA_WIDTH/2 bits.
- ADDR_WIDTH, 64, PC width.
- COUNT_WIDTH, 32, width of the issued-instruction counter.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  begin/restart sequencing; honoured only in IDLE or HALT.
- entry_pc  in  ADDR_WIDTH  first PC; bit 2 selects the starting half; bits 1:0 ignored (treated as 0).
- fetch_valid  in  1  fetch beat available.
- fetch_data  in  BUS_DATA_WIDTH  beat; [31:0] is at PC with PC[2]=0, [63:32] at PC with PC[2]=1.
- fetch_ready  out  1  sequencer accepts a beat this cycle.
- dec_valid  out  1  dec_instruction/dec_pc valid.
- dec_ready  in  1  decoder consumes this cycle.
- dec_instruction  out  BUS_DATA_WIDTH/2  instruction to the decoder.
- dec_pc  out  ADDR_WIDTH  PC of dec_instruction.
- halted  out  1  high in HALT.
- halt_pc  out  ADDR_WIDTH  PC of the terminating zero word; valid while halted.
- inst_count  out  COUNT_WIDTH  instructions transferred since the last start.

Behaviour:
- Reset (synchronous, takes effect at the edge, overrides all other inputs):
  - state=IDLE.
  - fetch_ready=0, dec_valid=0, dec_instruction=0, dec_pc=0, halted=0, halt_pc=0, inst_count=0.
  - Internal beat register and pc cleared.
  - Reset mid-operation discards any held beat; no partial transfer survives.
- States: IDLE, WAIT_BEAT, ISSUE_LO, ISSUE_HI, HALT.
- IDLE: all handshake outputs low. On start: pc<={entry_pc[ADDR_WIDTH-1:2],2'b00}, inst_count<=0, go to WAIT_BEAT.
- WAIT_BEAT:
  - fetch_ready=1 (registered/state-decoded, independent of fetch_valid).
  - On fetch_valid: latch fetch_data. Go to ISSUE_HI if pc[2]=1, else ISSUE_LO.
  - pc[2]=1 occurs only for the first beat after a start with entry_pc[2]=1; the lower half of that beat is discarded.
- ISSUE_LO / ISSUE_HI:
  - Selected half = beat[31:0] or beat[63:32]. dec_instruction=selected half, dec_pc=pc.
  - Zero detection: if the selected half == 0, dec_valid=0. Next cycle: state=HALT, halt_pc<=pc, halted=1. The zero word is never presented and never counted.
  - Otherwise dec_valid=1; hold dec_instruction/dec_pc stable until dec_ready.
  - On dec_valid&&dec_ready: pc<=pc+4, inst_count<=inst_count+1 (wraps modulo 2^COUNT_WIDTH). ISSUE_LO goes to ISSUE_HI; ISSUE_HI goes to WAIT_BEAT.
  - dec_ready while dec_valid=0 has no effect.
- Latency:
  - Beat accepted at edge N gives dec_valid at cycle N+1.
  - Upper half presented the cycle after the lower-half transfer.
  - fetch_ready reasserts the cycle after the upper-half transfer.
  - Peak throughput: 2 instructions per 3 cycles. No back-to-back beat acceptance.
- HALT:
  - halted=1; fetch_ready=0, dec_valid=0.
  - inst_count and halt_pc hold.
  - start behaves as in IDLE and clears halted in the same edge.
- start outside IDLE/HALT is ignored.
- If reset and start are high together, reset wins.
- fetch_valid outside WAIT_BEAT is ignored; data not consumed.
- pc wraps modulo 2^ADDR_WIDTH.

Test Plan:
- Basic: start, entry_pc=0x1000; beat 0x00500093_00a00513, then beat 0x00000000_00000000, dec_ready=1.
  - Required transfers: 0x00a00513@0x1000, 0x00500093@0x1004.
  - Then HALT with halt_pc=0x1008, inst_count=2.
  - fetch_ready low one cycle after beat 1 accepted; high again one cycle after the 0x1004 transfer.
- Backpressure: same stream, dec_ready=0 for 5 cycles after dec_valid rises.
  - dec_instruction=0x00a00513 and dec_pc=0x1000 held stable all 5 cycles; inst_count stays 0 until the transfer.
- Misaligned entry: entry_pc=0x2004; beat 0x00000013_deadbeef, then beat 0.
  - Only 0x00000013@0x2004 issued; then halt_pc=0x2008, inst_count=1.
- Zero in upper half: beat 0x00000000_00000013.
  - One transfer 0x13@PC.
  - dec_valid never rises for the upper half; halted=1 with halt_pc=PC+4.
- Restart and reset:
  - From HALT, start with entry_pc=0x3000: halted falls, inst_count=0, fetch_ready=1 next cycle.
  - Assert reset while in ISSUE_LO with dec_valid=1: all outputs 0 at the next edge, state IDLE.
  - start ignored while in WAIT_BEAT: pc unchanged.
- Counter wrap: COUNT_WIDTH=4, issue 17 non-zero instructions; inst_count reads 1.
